tawa_encoder_emu: RTL and testbench

TAWA_ENCODER_EMU -- requirements
Module: tawa_encoder_emu

---
 rtl/tawa_encoder_emu.sv | 148 ++++++++++++++
 tb/tb_tawa_encoder_emu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tawa_encoder_emu.sv
// rtl/tawa_encoder_emu.sv - serial absolute encoder emulator answering DF0..DF3 requests over a byte uart
// Optional trailing XOR CRC byte is enabled by defining TAWA_EMU_CRC_EN.
module tawa_encoder_emu #(
    parameter int RESP_DLY = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    input  logic [23:0] angle_in,
    input  logic [23:0] turn_in,
    input  logic [7:0]  sf_in,
    input  logic [7:0]  almc_in,
    input  logic [7:0]  enid_in,
    output logic [7:0]  tx_data,
    output logic        tx_send_en,
    output logic        de,
    output logic [15:0] req_cnt
);

    typedef enum logic [2:0] {IDLE, WAIT, LOAD, BUSYH, BUSYL, DONE} state_t;

    localparam int CW = (RESP_DLY > 1) ? $clog2(RESP_DLY) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((RESP_DLY > 0) ? RESP_DLY - 1 : 0);
`ifdef TAWA_EMU_CRC_EN
    localparam logic [3:0] CRC_LEN = 4'd1;
`else
    localparam logic [3:0] CRC_LEN = 4'd0;
`endif

    state_t        state, next_state;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    idx;
    logic [3:0]    data_len;
    logic [3:0]    frame_last;
    logic [7:0]    data_byte;
    logic [7:0]    cf_q, sf_q, almc_q, enid_q;
    logic [23:0]   angle_q, turn_q;
    logic          accept;

    assign accept = (state == IDLE) && rx_valid &&
                    (rx_data == 8'h02 || rx_data == 8'h8A || rx_data == 8'h92 || rx_data == 8'h1A);

    always_comb begin
        data_len = 4'd10;
        case (cf_q)
            8'h02, 8'h8A: data_len = 4'd5;
            8'h92:        data_len = 4'd3;
            default:      data_len = 4'd10;
        endcase
    end

    assign frame_last = data_len + CRC_LEN - 4'd1;

    // Byte selection is driven purely by the latched command and byte index.
    always_comb begin
        data_byte = cf_q;
        if (idx == 4'd1) begin
            data_byte = sf_q;
        end else if (idx != 4'd0) begin
            case (cf_q)
                8'h02: data_byte = angle_q[8*(idx-4'd2) +: 8];
                8'h8A: data_byte = turn_q[8*(idx-4'd2) +: 8];
                8'h92: data_byte = enid_q;
                default: begin
                    case (idx)
                        4'd2:    data_byte = angle_q[7:0];
                        4'd3:    data_byte = angle_q[15:8];
                        4'd4:    data_byte = angle_q[23:16];
                        4'd5:    data_byte = enid_q;
                        4'd6:    data_byte = turn_q[7:0];
                        4'd7:    data_byte = turn_q[15:8];
                        4'd8:    data_byte = turn_q[23:16];
                        default: data_byte = almc_q;
                    endcase
                end
            endcase
        end
    end

`ifdef TAWA_EMU_CRC_EN
    logic [7:0] crc_q;

    assign tx_data = (idx == data_len) ? crc_q : data_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else if (accept) begin
            crc_q <= 8'h00;
        end else if (state == LOAD && idx < data_len) begin
            crc_q <= crc_q ^ data_byte;
        end
    end
`else
    assign tx_data = data_byte;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (RESP_DLY == 0) ? LOAD : WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) next_state = LOAD;
            LOAD:    next_state = BUSYH;
            BUSYH:   if (tx_busy) next_state = BUSYL;
            BUSYL:   if (!tx_busy) next_state = (idx == frame_last) ? DONE : LOAD;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_send_en <= 1'b0;
            de         <= 1'b0;
            req_cnt    <= 16'h0000;
            wait_cnt   <= '0;
            idx        <= 4'd0;
            cf_q       <= 8'h00;
            sf_q       <= 8'h00;
            almc_q     <= 8'h00;
            enid_q     <= 8'h00;
            angle_q    <= 24'h0;
            turn_q     <= 24'h0;
        end else begin
            state      <= next_state;
            tx_send_en <= (next_state == LOAD);
            de         <= (next_state == LOAD) || (next_state == BUSYH) || (next_state == BUSYL);
            if (accept) begin
                cf_q     <= rx_data;
                sf_q     <= sf_in;
                almc_q   <= almc_in;
                enid_q   <= enid_in;
                angle_q  <= angle_in;
                turn_q   <= turn_in;
                req_cnt  <= req_cnt + 16'd1;
                wait_cnt <= '0;
                idx      <= 4'd0;
            end else begin
                if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
                if (state == BUSYL && next_state == LOAD) idx <= idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_tawa_encoder_emu.sv
// tb/tb_tawa_encoder_emu.sv - scoreboard bench with uart sender model for tawa_encoder_emu
module tb_tawa_encoder_emu;

    localparam int DLY = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic [23:0] angle_in = 24'h0;
    logic [23:0] turn_in = 24'h0;
    logic [7:0]  sf_in = 8'h00;
    logic [7:0]  almc_in = 8'h00;
    logic [7:0]  enid_in = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_send_en;
    logic        de;
    logic [15:0] req_cnt;

    tawa_encoder_emu #(.RESP_DLY(DLY)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
        .angle_in(angle_in), .turn_in(turn_in), .sf_in(sf_in), .almc_in(almc_in), .enid_in(enid_in),
        .tx_data(tx_data), .tx_send_en(tx_send_en), .de(de), .req_cnt(req_cnt)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          sent_cnt = 0;
    int          issue_cyc = 0;
    int          first_send_cyc = -1;
    bit          want_delay = 0;
    bit          stable_armed = 0;
    logic [7:0]  last_sent = 8'h00;
    logic [15:0] req_exp = 16'h0;
    logic [7:0]  exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_cmd(input logic [7:0] c);
        return c == 8'h02 || c == 8'h8A || c == 8'h92 || c == 8'h1A;
    endfunction

    // Reference frame builder: field order from the frame tables, CRC = XOR of all prior bytes.
    function automatic void push_frame(input logic [7:0] cf);
        logic [7:0] f[$];
        logic [7:0] crc;
        f.push_back(cf);
        f.push_back(sf_in);
        case (cf)
            8'h02: f = {f, angle_in[7:0], angle_in[15:8], angle_in[23:16]};
            8'h8A: f = {f, turn_in[7:0], turn_in[15:8], turn_in[23:16]};
            8'h92: f.push_back(enid_in);
            default: f = {f, angle_in[7:0], angle_in[15:8], angle_in[23:16], enid_in,
                          turn_in[7:0], turn_in[15:8], turn_in[23:16], almc_in};
        endcase
        crc = 8'h00;
        foreach (f[i]) begin
            crc ^= f[i];
            exp_q.push_back(f[i]);
        end
`ifdef TAWA_EMU_CRC_EN
        exp_q.push_back(crc);
`endif
    endfunction

    task automatic issue(input logic [7:0] cmd, input bit accept_ok);
        @(posedge clk);
        #1;
        rx_data  = cmd;
        rx_valid = 1'b1;
        issue_cyc = cyc;
        if (accept_ok && is_cmd(cmd)) begin
            push_frame(cmd);
            req_exp = req_exp + 16'd1;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        angle_in = 24'($urandom);
        turn_in  = 24'($urandom);
        sf_in    = 8'($urandom);
        almc_in  = 8'($urandom);
        enid_in  = 8'($urandom);
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || de) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, n < 3000, 1);
        repeat (3) @(negedge clk);
        check({name, "_req_cnt"}, req_cnt, req_exp);
        check({name, "_de_low"}, de, 0);
    endtask

    // Uart sender model: raises busy some cycles after a request, then drops it.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_send_en && rst_n) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                #2 tx_busy = 1'b1;
                repeat ($urandom_range(2, 6)) @(negedge clk);
                #2 tx_busy = 1'b0;
            end
        end
    end

    logic prev_busy = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (tx_send_en) begin
                check("send_while_busy", tx_busy, 0);
                check("de_at_send", de, 1);
                if (want_delay) begin
                    first_send_cyc = cyc;
                    want_delay = 0;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_send: got byte 0x%0h expected no send", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_q.pop_front());
                end
                last_sent = tx_data;
                stable_armed = 1;
                sent_cnt++;
            end else if (tx_busy && stable_armed && rst_n) begin
                check("tx_data_stable", tx_data, last_sent);
                check("de_during_busy", de, 1);
            end
            prev_busy = tx_busy;
        end
    end

    initial begin
        int base;
        logic [7:0] cmds[5];
        repeat (3) @(negedge clk);
        check("rst_tx_data", tx_data, 0);
        check("rst_send_en", tx_send_en, 0);
        check("rst_de", de, 0);
        check("rst_req_cnt", req_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // DF0 with fixed fields plus response latency
        angle_in = 24'h123456; sf_in = 8'h00;
        want_delay = 1;
        issue(8'h02, 1);
        wait_frame("df0");
        check("resp_delay", first_send_cyc - issue_cyc, DLY + 1);

        // DF3 with fixed fields
        angle_in = 24'h000001; turn_in = 24'h000002; enid_in = 8'h17; almc_in = 8'h00; sf_in = 8'h00;
        issue(8'h1A, 1);
        wait_frame("df3");

        // DF2 with ENID 0x17
        enid_in = 8'h17; sf_in = 8'h00;
        issue(8'h92, 1);
        wait_frame("df2");

        issue(8'h8A, 1);
        wait_frame("df1");

        // Non-command byte is ignored
        base = sent_cnt;
        issue(8'h55, 1);
        repeat (DLY + 30) @(negedge clk);
        check("ignore_no_send", sent_cnt, base);
        check("ignore_req_cnt", req_cnt, req_exp);

        // Second request mid-frame is dropped
        issue(8'h02, 1);
        base = sent_cnt;
        for (int n = 0; n < 2000 && sent_cnt < base + 2; n++) @(negedge clk);
        issue(8'h02, 0);
        wait_frame("df0_dup");

        cmds = '{8'h02, 8'h8A, 8'h92, 8'h1A, 8'h00};
        for (int i = 0; i < 10; i++) begin
            logic [7:0] c;
            c = cmds[$urandom_range(0, 4)];
            if (c == 8'h00) c = 8'($urandom);
            issue(c, 1);
            if (!is_cmd(c)) repeat (DLY + 10) @(negedge clk);
            wait_frame("rand");
        end

        // Reset mid-DF3 aborts the frame
        issue(8'h1A, 1);
        base = sent_cnt;
        for (int n = 0; n < 2000 && sent_cnt < base + 3; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        stable_armed = 0;
        rst_n = 1'b0;
        #1;
        check("abort_de", de, 0);
        check("abort_send_en", tx_send_en, 0);
        exp_q.delete();
        req_exp = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = sent_cnt;
        repeat (2 * DLY + 60) @(negedge clk);
        check("abort_no_more", sent_cnt, base);
        check("abort_req_cnt", req_cnt, 0);

        issue(8'h92, 1);
        wait_frame("recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
